// File: rtl/rr_arb_mux.sv
`timescale 1ns/1ps
// N-input registered arbiter/mux: direct-select, fixed-priority or round-robin grant into one output register.
// Latency 1 cycle; an input is accepted only while the output register is empty or draining, so a stalled output blocks every channel.
module rr_arb_mux #(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0]       MODE_DIRECT = 2'd0;
  localparam logic [1:0]       MODE_FIXED  = 2'd1;
  localparam logic [1:0]       MODE_RR     = 2'd2;
  localparam logic [SEL_W-1:0] LAST_RST    = SEL_W'(N - 1);

  typedef struct packed {
    logic [SEL_W-1:0] chan;
    logic [W-1:0]     dat;
  } out_t;

  out_t             out_q;
  logic             out_vld_q;
  logic [SEL_W-1:0] last_q;

  logic             load_en;
  logic             dir_vld, fp_vld, hi_vld, gnt_vld;
  logic [SEL_W-1:0] dir_idx, fp_idx, hi_idx, gnt_idx;
  logic [W-1:0]     gnt_dat;
  logic             xfer;

  assign load_en = !out_vld_q || out_ready;

  // Direct select: compare against each legal index so an out-of-range sel simply matches nothing.
  always_comb begin
    dir_vld = 1'b0;
    dir_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) begin
        dir_vld = 1'b1;
        dir_idx = SEL_W'(i);
      end
    end
  end

  // Lowest valid index; scanning downward lets the lowest index overwrite.
  always_comb begin
    fp_vld = 1'b0;
    fp_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_vld = 1'b1;
        fp_idx = SEL_W'(i);
      end
    end
  end

  // Round-robin: lowest valid index strictly above last, else wrap to the lowest valid overall.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i] && SEL_W'(i) > last_q) begin
        hi_vld = 1'b1;
        hi_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    case (mode)
      MODE_DIRECT: begin
        gnt_vld = dir_vld;
        gnt_idx = dir_idx;
      end
      MODE_FIXED: begin
        gnt_vld = fp_vld;
        gnt_idx = fp_idx;
      end
      MODE_RR: begin
        gnt_vld = fp_vld;
        gnt_idx = hi_vld ? hi_idx : fp_idx;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
      end
    endcase
  end

  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_dat = in_data[i*W +: W];
    end
  end

  assign xfer = gnt_vld && load_en;

  // rstb gates in_ready directly because the emptied output register alone would otherwise advertise space.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rstb && xfer && (gnt_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (xfer) begin
      out_q.chan <= gnt_idx;
      out_q.dat  <= gnt_dat;
      out_vld_q  <= 1'b1;
    end else if (out_ready) begin
      out_vld_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      last_q <= LAST_RST;
    end else if (xfer && mode == MODE_RR) begin
      last_q <= gnt_idx;
    end
  end

  assign out_data  = out_q.dat;
  assign out_chan  = out_q.chan;
  assign out_valid = out_vld_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
`timescale 1ns/1ps
// Randomized and directed bench for rr_arb_mux against a cycle-level behavioural model.
module tb_rr_arb_mux;

  localparam int N     = 5;
  localparam int W     = 32;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rstb;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid;
  logic             out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: what the output register should hold and the last RR winner.
  logic         m_vld;
  logic [W-1:0] m_dat;
  int           m_chan;
  int           m_last;

  int rr_exp[7] = '{0, 1, 2, 3, 4, 0, 1};

  rr_arb_mux #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    case (mode)
      2'd0: if (int'(sel) < N && in_valid[sel]) return int'(sel);
      2'd1: for (int i = 0; i < N; i++) if (in_valid[i]) return i;
      2'd2: for (int k = 1; k <= N; k++) begin
              int c;
              c = (m_last + k) % N;
              if (in_valid[c]) return c;
            end
      default: return -1;
    endcase
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  // Called just after a rising edge with inputs already driven; checks, advances model, steps one clock.
  task automatic cycle();
    int g;
    logic ld;
    logic [N-1:0] er;
    #2;
    if (!rstb) begin
      m_vld = 1'b0; m_dat = '0; m_chan = 0; m_last = N - 1;
    end
    g  = model_grant();
    ld = !m_vld || out_ready;
    er = '0;
    if (rstb && g >= 0 && ld) er[g] = 1'b1;
    chk("in_ready",  64'(in_ready),  64'(er));
    chk("out_valid", 64'(out_valid), 64'(m_vld));
    chk("out_data",  64'(out_data),  64'(m_dat));
    chk("out_chan",  64'(out_chan),  64'(m_chan));
    if (rstb) begin
      if (er != '0) begin
        m_vld  = 1'b1;
        m_dat  = in_data[g*W +: W];
        m_chan = g;
        if (mode == 2'd2) m_last = g;
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb = 1'b0; mode = 2'd2; sel = '0; in_valid = '1; out_ready = 1'b1;
    rand_data();
    m_vld = 1'b0; m_dat = '0; m_chan = 0; m_last = N - 1;

    // Reset held with all channels valid, then first RR grant.
    repeat (3) cycle();
    rstb = 1'b1;
    cycle();
    chk("rr_first_chan", 64'(out_chan), 64'd0);

    // Direct select, then out-of-range select.
    mode = 2'd0; sel = 3'd3; in_valid = 5'b11111;
    in_data[3*W +: W] = 32'hDEADBEEF;
    cycle();
    chk("dir_data", 64'(out_data), 64'hDEADBEEF);
    chk("dir_chan", 64'(out_chan), 64'd3);
    sel = 3'd6;
    cycle();
    chk("dir_oor_drain", 64'(out_valid), 64'd0);
    cycle();

    // Fixed priority starves channels 2 and 4.
    mode = 2'd1; in_valid = 5'b10110;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
      chk("fp_chan", 64'(out_chan), 64'd1);
    end

    // Fresh RR pointer, then fairness sequence.
    rstb = 1'b0;
    cycle();
    rstb = 1'b1; mode = 2'd2; in_valid = '1;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      cycle();
      chk("rr_seq_chan", 64'(out_chan), 64'(rr_exp[i]));
      chk("rr_seq_vld",  64'(out_valid), 64'd1);
    end

    // Backpressure for 4 cycles, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_chan", 64'(out_chan), 64'd2);
    cycle();

    // Asynchronous reset mid-cycle with a held word and last=2.
    rstb = 1'b0;
    cycle();
    rstb = 1'b1; mode = 2'd2; in_valid = '1; out_ready = 1'b1;
    repeat (3) cycle();
    chk("pre_rst_chan", 64'(out_chan), 64'd2);
    chk("pre_rst_vld",  64'(out_valid), 64'd1);
    #2;
    rstb = 1'b0;
    #1;
    chk("async_rst_vld", 64'(out_valid), 64'd0);
    chk("async_rst_rdy", 64'(in_ready),  64'd0);
    @(posedge clk);
    #1;
    cycle();
    rstb = 1'b1;
    cycle();
    chk("post_rst_rr_chan", 64'(out_chan), 64'd0);

    // Random traffic including occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      int r;
      r         = $urandom_range(0, 9);
      mode      = (r == 9) ? 2'd3 : 2'(r % 3);
      sel       = SEL_W'($urandom_range(0, 7));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rstb      = ($urandom_range(0, 99) != 0);
      rand_data();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
